fib_stream_checker: RTL and testbench
=====================================

# fib_stream_checker

Consumes the 8-bit wrap-around Fibonacci stream (0,1,1,2,3,5,…,144,233,0,1,…) produced by the upstream Fibonacci generator and checks every term against an internal reference model. It locks onto the sequence at a 0 term, flags any mismatching term, counts errors and completed sequence periods, and reports the position of the current term. It sits directly downstream of the generator's `number` output and serves as the on-chip self-check for that stage.

## Interface
- `CNT_W`, default 8: width of `err_count` and `wrap_count`.
- `clk`  input  1  rising-edge clock, shared with the generator.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  `in_number` carries a term this cycle. Tie it to 1 when the generator runs every cycle.
- `in_number`  input  8  term under check.
- `locked`  output  1  the checker is in the CHK state.
- `err`  output  1  one-cycle pulse: the previous valid term mismatched while locked.
- `wrap`  output  1  one-cycle pulse: a correct overflow-restart 0 was just accepted.
- `term_idx`  output  4  index of the last accepted term within its period (0..13).
- `err_count`  output  CNT_W  mismatch count, saturating at all-ones.
- `wrap_count`  output  CNT_W  completed-period count, wraps modulo 2^CNT_W.

## Operation
- **Reference model.** Two 8-bit registers, `ref_cur` and `ref_prev`, with a 9-bit sum.
  - `exp = (ref_prev + ref_cur)[8] ? 0 : (ref_prev + ref_cur)[7:0]`.
  - On overflow the model reloads `ref_cur = 0`, `ref_prev = 1`, matching the generator's restart.
- **States:** SYNC and CHK. The FSM evaluates only on cycles with `in_valid = 1`; when `in_valid = 0` all state and outputs hold, except `err` and `wrap`, which clear.
- **SYNC.**
  - `in_number == 0`: go to CHK, load `ref_cur = 0`, `ref_prev = 1`, `term_idx = 0`.
  - Any other value: stay in SYNC. No error is raised.
- **CHK, `in_number == exp`.**
  - Advance the model: `ref_prev <= ref_cur`, `ref_cur <= exp` (or reload on overflow).
  - If `exp` came from overflow: `term_idx <= 0`, pulse `wrap`, increment `wrap_count`.
  - Otherwise: `term_idx <= term_idx + 1`.
- **CHK, mismatch.**
  - Always: pulse `err`; `err_count` increments unless it is already all-ones.
  - If `in_number == 0`: resynchronise in place. Stay in CHK, reload the model as in SYNC, set `term_idx = 0`. `wrap` does not pulse.
  - Otherwise: go to SYNC.
- **Width rules.**
  - The sum is 9 bits wide; bit 8 alone decides overflow. `exp` of 0 arises only from overflow.
  - The expected period is exactly 14 terms (indices 0..13, term 13 = 233).
- **Reset** has priority over everything, including a mid-sequence sample. State goes to SYNC and all outputs go to 0.

## Timing
- All outputs are registered. A sample accepted on clock edge N shows its result (`locked`, `err`, `wrap`, `term_idx`, counters) after edge N, i.e. in cycle N+1. Latency is 1 cycle.
- `err` and `wrap` are high for exactly one cycle per triggering sample and never both in the same cycle.
- `locked` rises in the cycle after the first accepted 0. It falls in the cycle after a non-zero mismatch.
- Back-to-back valid samples are checked every cycle, with no bubbles required.
- A sample present while `reset` is high is ignored. The first sample evaluated is the one on the first edge with `reset` low.
- Reset values: `locked = 0`, `err = 0`, `wrap = 0`, `term_idx = 0`, `err_count = 0`, `wrap_count = 0`, state SYNC, `ref_cur = 0`, `ref_prev = 1`.
- Interaction with the generator: its reset output is 0 on the first edge after reset, so the checker locks 1 cycle after both blocks leave reset.

## Test plan
- **Connected to the generator, `in_valid = 1`, 30 cycles after reset:** `locked = 1` from cycle 1. `wrap` pulses when the second and third 0 are accepted, 14 and 28 samples after the first. `wrap_count = 2`, `err` never high, `term_idx` reads 13 on the sample of 233.
- **Stream 0,1,1,2,3,5,8,14 then 21:** `err` pulses one cycle after 14, `err_count = 1`, `locked` drops. 21 is ignored in SYNC with no further `err`. The next 0 relocks.
- **Locked at term 8 (value 21), drive 0:** `err` pulses, `err_count = 1`, `locked` stays 1, `term_idx = 0`. A following 1,1,2 produces no error.
- **Full correct period with `in_valid` toggling 1,0,1,0:** results identical to the contiguous case. Outputs hold during invalid cycles, and `err`/`wrap` are never stretched.
- **Reset asserted while `term_idx = 9`:** all outputs are 0 the next cycle and state is SYNC. A first post-reset sample of 5 causes no lock and no error.
- **`CNT_W = 2`, 5 consecutive non-zero mismatches, relocking on a 0 each time:** `err_count` saturates at 3. **`CNT_W = 2`, 5 correct periods:** `wrap_count` reads 1.

Source files
------------

// File: rtl/fib_stream_checker.sv
// Purpose : checks an 8-bit wrap-around Fibonacci stream against an internal reference model.
// Latency : 1 cycle; every output is registered, and a sample accepted on edge N is reflected in cycle N+1.
// Backpr. : none; the checker never stalls. Cycles with in_valid low hold state and clear the err/wrap pulses.
//
// Ports:
//   clk, reset  - rising-edge clock; synchronous active-high reset
//   in_valid    - in_number carries a term this cycle
//   in_number   - 8-bit term under check
//   locked      - checker is in the CHK state
//   err         - one-cycle pulse: the previous valid term mismatched while locked
//   wrap        - one-cycle pulse: a correct overflow-restart 0 was accepted
//   term_idx    - position of the last accepted term within its period (0..13)
//   err_count   - mismatch count, saturating at all-ones
//   wrap_count  - completed-period count, wrapping modulo 2^CNT_W
module fib_stream_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_number,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [3:0]       term_idx,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  typedef enum logic {SYNC, CHK} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [7:0]       ref_cur, ref_prev;
  logic [7:0]       ref_cur_nxt, ref_prev_nxt;
  logic [3:0]       term_idx_nxt;
  logic             err_nxt, wrap_nxt;
  logic [CNT_W-1:0] err_count_nxt, wrap_count_nxt;

  // Reference model: the 9th sum bit alone marks the generator's overflow restart.
  logic [8:0] sum;
  logic       ovf;
  logic [7:0] exp_num;

  assign sum     = {1'b0, ref_prev} + {1'b0, ref_cur};
  assign ovf     = sum[8];
  assign exp_num = ovf ? 8'd0 : sum[7:0];

  assign locked  = (state == CHK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SYNC;
      ref_cur    <= 8'd0;
      ref_prev   <= 8'd1;
      term_idx   <= 4'd0;
      err        <= 1'b0;
      wrap       <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      state      <= state_nxt;
      ref_cur    <= ref_cur_nxt;
      ref_prev   <= ref_prev_nxt;
      term_idx   <= term_idx_nxt;
      err        <= err_nxt;
      wrap       <= wrap_nxt;
      err_count  <= err_count_nxt;
      wrap_count <= wrap_count_nxt;
    end
  end

  always_comb begin
    // Default: hold everything; the pulse outputs fall back to 0.
    state_nxt      = state;
    ref_cur_nxt    = ref_cur;
    ref_prev_nxt   = ref_prev;
    term_idx_nxt   = term_idx;
    err_nxt        = 1'b0;
    wrap_nxt       = 1'b0;
    err_count_nxt  = err_count;
    wrap_count_nxt = wrap_count;

    if (in_valid) begin
      unique case (state)
        SYNC: begin
          if (in_number == 8'd0) begin
            state_nxt    = CHK;
            ref_cur_nxt  = 8'd0;
            ref_prev_nxt = 8'd1;
            term_idx_nxt = 4'd0;
          end
        end

        CHK: begin
          if (in_number == exp_num) begin
            if (ovf) begin
              // The generator restarts at 0,1,... so the model reloads its seed pair.
              ref_cur_nxt    = 8'd0;
              ref_prev_nxt   = 8'd1;
              term_idx_nxt   = 4'd0;
              wrap_nxt       = 1'b1;
              wrap_count_nxt = wrap_count + CNT_ONE;
            end else begin
              ref_prev_nxt = ref_cur;
              ref_cur_nxt  = exp_num;
              term_idx_nxt = term_idx + 4'd1;
            end
          end else begin
            err_nxt = 1'b1;
            if (!(&err_count)) begin
              err_count_nxt = err_count + CNT_ONE;
            end
            if (in_number == 8'd0) begin
              // An unexpected 0 is still a valid sequence start: relock in place.
              ref_cur_nxt  = 8'd0;
              ref_prev_nxt = 8'd1;
              term_idx_nxt = 4'd0;
            end else begin
              state_nxt = SYNC;
            end
          end
        end

        default: state_nxt = SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_stream_checker.sv
module tb_fib_stream_checker;

  localparam logic [7:0] FIB [14] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8,
                                      8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_number = 8'd0;

  logic       locked, err, wrap;
  logic [3:0] term_idx;
  logic [7:0] err_count, wrap_count;
  logic       locked2, err2, wrap2;
  logic [3:0] term_idx2;
  logic [1:0] err_count2, wrap_count2;

  always #5 clk = ~clk;

  fib_stream_checker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_number(in_number),
    .locked(locked), .err(err), .wrap(wrap), .term_idx(term_idx),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  fib_stream_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_number(in_number),
    .locked(locked2), .err(err2), .wrap(wrap2), .term_idx(term_idx2),
    .err_count(err_count2), .wrap_count(wrap_count2)
  );

  typedef struct packed {
    logic       locked;
    logic       err;
    logic       wrap;
    logic [3:0] idx;
    logic [7:0] errc;
    logic [7:0] wrapc;
    logic [1:0] errc2;
    logic [1:0] wrapc2;
  } exp_t;

  exp_t exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_err_seen  = 0;
  int n_wrap_seen = 0;

  // Behavioural model: tracks position in the 14-entry table rather than an adder.
  logic       m_locked = 1'b0;
  logic       m_err = 1'b0;
  logic       m_wrap = 1'b0;
  logic [3:0] m_idx = 4'd0;
  int         m_errc = 0;
  int         m_wrapc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] n);
    logic [3:0] nxt;
    m_err  = 1'b0;
    m_wrap = 1'b0;
    if (r) begin
      m_locked = 1'b0; m_idx = 4'd0; m_errc = 0; m_wrapc = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (n == 8'd0) begin
          m_locked = 1'b1; m_idx = 4'd0;
        end
      end else begin
        nxt = (m_idx == 4'd13) ? 4'd0 : m_idx + 4'd1;
        if (n == FIB[nxt]) begin
          m_idx = nxt;
          if (nxt == 4'd0) begin
            m_wrap = 1'b1; m_wrapc++;
          end
        end else begin
          m_err = 1'b1; m_errc++;
          if (n == 8'd0) m_idx = 4'd0;
          else           m_locked = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive at the falling edge, predict, compare just after the rising edge.
  task automatic drive(input logic r, input logic v, input logic [7:0] n);
    exp_t e;
    @(negedge clk);
    reset = r; in_valid = v; in_number = n;
    model_step(r, v, n);
    e.locked = m_locked;
    e.err    = m_err;
    e.wrap   = m_wrap;
    e.idx    = m_idx;
    e.errc   = (m_errc > 255) ? 8'd255 : 8'(m_errc);
    e.errc2  = (m_errc > 3) ? 2'd3 : 2'(m_errc);
    e.wrapc  = 8'(m_wrapc);
    e.wrapc2 = 2'(m_wrapc);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("locked", 32'(locked), 32'(e.locked));
    check("err", 32'(err), 32'(e.err));
    check("wrap", 32'(wrap), 32'(e.wrap));
    check("term_idx", 32'(term_idx), 32'(e.idx));
    check("err_count", 32'(err_count), 32'(e.errc));
    check("wrap_count", 32'(wrap_count), 32'(e.wrapc));
    check("err_count_w2", 32'(err_count2), 32'(e.errc2));
    check("wrap_count_w2", 32'(wrap_count2), 32'(e.wrapc2));
    check("err_wrap_excl", 32'(err & wrap), 32'd0);
    n_err_seen  += int'(err);
    n_wrap_seen += int'(wrap);
  endtask

  task automatic clear_tallies();
    n_err_seen = 0;
    n_wrap_seen = 0;
  endtask

  initial begin
    // Reset state
    drive(1'b1, 1'b1, 8'd7);
    drive(1'b1, 1'b1, 8'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_idx", 32'(term_idx), 32'd0);
    check("rst_errc", 32'(err_count), 32'd0);

    // Generator-connected run: 30 contiguous samples
    clear_tallies();
    for (int k = 0; k < 30; k++) begin
      drive(1'b0, 1'b1, FIB[k % 14]);
      check("gen_locked", 32'(locked), 32'd1);
      if (k == 13) check("idx_at_233", 32'(term_idx), 32'd13);
      if (k == 14 || k == 28) check("wrap_at_zero", 32'(wrap), 32'd1);
    end
    check("gen_wrap_count", 32'(wrap_count), 32'd2);
    check("gen_wrap_pulses", 32'(n_wrap_seen), 32'd2);
    check("gen_err_pulses", 32'(n_err_seen), 32'd0);

    // Non-zero mismatch drops lock; the following 21 is ignored in SYNC
    drive(1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 7; k++) drive(1'b0, 1'b1, FIB[k]);
    drive(1'b0, 1'b1, 8'd14);
    check("bad14_err", 32'(err), 32'd1);
    check("bad14_errc", 32'(err_count), 32'd1);
    check("bad14_locked", 32'(locked), 32'd0);
    drive(1'b0, 1'b1, 8'd21);
    check("sync21_err", 32'(err), 32'd0);
    check("sync21_locked", 32'(locked), 32'd0);
    drive(1'b0, 1'b1, 8'd0);
    check("relock", 32'(locked), 32'd1);

    // Zero mismatch at term 8 resynchronises in place
    drive(1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 9; k++) drive(1'b0, 1'b1, FIB[k]);
    check("pre_idx8", 32'(term_idx), 32'd8);
    drive(1'b0, 1'b1, 8'd0);
    check("z_err", 32'(err), 32'd1);
    check("z_locked", 32'(locked), 32'd1);
    check("z_idx", 32'(term_idx), 32'd0);
    check("z_errc", 32'(err_count), 32'd1);
    drive(1'b0, 1'b1, 8'd1);
    drive(1'b0, 1'b1, 8'd1);
    drive(1'b0, 1'b1, 8'd2);
    check("z_follow_errc", 32'(err_count), 32'd1);
    check("z_follow_idx", 32'(term_idx), 32'd3);

    // Full period with valid toggling; invalid cycles carry junk
    drive(1'b1, 1'b0, 8'd0);
    clear_tallies();
    for (int k = 0; k < 15; k++) begin
      drive(1'b0, 1'b1, FIB[k % 14]);
      drive(1'b0, 1'b0, 8'($urandom_range(1, 255)));
      check("hold_idx", 32'(term_idx), 32'(k % 14));
    end
    check("tog_wrap_count", 32'(wrap_count), 32'd1);
    check("tog_wrap_pulses", 32'(n_wrap_seen), 32'd1);
    check("tog_err_pulses", 32'(n_err_seen), 32'd0);

    // Reset mid-sequence at term 9
    drive(1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, FIB[k]);
    check("pre_idx9", 32'(term_idx), 32'd9);
    drive(1'b1, 1'b1, 8'd55);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_idx", 32'(term_idx), 32'd0);
    drive(1'b0, 1'b1, 8'd5);
    check("post_rst5_locked", 32'(locked), 32'd0);
    check("post_rst5_err", 32'(err), 32'd0);

    // Narrow counters: error saturation
    drive(1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 8'd0);
      drive(1'b0, 1'b1, 8'd7);
    end
    check("sat_errc2", 32'(err_count2), 32'd3);
    check("sat_errc8", 32'(err_count), 32'd5);

    // Narrow counters: wrap count modulo 4 after 5 periods
    drive(1'b1, 1'b0, 8'd0);
    for (int k = 0; k <= 70; k++) drive(1'b0, 1'b1, FIB[k % 14]);
    check("mod_wrapc2", 32'(wrap_count2), 32'd1);
    check("mod_wrapc8", 32'(wrap_count), 32'd5);

    // Mixed traffic: random valid gaps and occasional corrupted terms
    drive(1'b1, 1'b0, 8'd0);
    begin
      int g = 0;
      for (int c = 0; c < 300; c++) begin
        logic v;
        logic [7:0] n;
        v = ($urandom_range(0, 3) != 0);
        n = FIB[g];
        if ($urandom_range(0, 15) == 0) n = 8'($urandom_range(0, 255));
        if (v) g = (g + 1) % 14;
        drive(1'b0, v, n);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
